// File: rtl/seq_mult_32bit.sv
// seq_mult_32bit: iterative unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One ripple-carry add per clock, WIDTH iterations, result registered and held until the next completion.
module seq_mult_32bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m, acc, q;
    logic             c;
    logic [5:0]       cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic             c_nxt;
    logic             last_iter;

    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic             cin);
        logic [WIDTH:0] r;
        logic           cy;
        r  = '0;
        cy = cin;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[i] ^ y[i] ^ cy;
            cy   = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
        end
        r[WIDTH] = cy;
        return r;
    endfunction

    // c always enters an add as 0: it is cleared on capture and a zero is shifted into it every iteration.
    always_comb begin
        addend                   = q[0] ? m : '0;
        sum                      = ripple_add(acc, addend, c);
        {c_nxt, acc_nxt, q_nxt}  = {sum, q} >> 1;
        last_iter                = (cnt == 6'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    c   <= c_nxt;
                    cnt <= cnt + 6'd1;
                    if (last_iter) product <= {acc_nxt, q_nxt};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_32bit.sv
// Scoreboard bench for seq_mult_32bit: expected products are queued at each accepting edge
// and popped by a monitor whenever done is seen; busy/done timing is predicted per cycle.
module tb_seq_mult_32bit;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    seq_mult_32bit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_abort  = 0;
    int n_done   = 0;
    int rem      = 0;          // edges left until the model returns to idle
    logic [63:0] exp_q[$];
    logic [63:0] last_prod = '0;

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: operation accepted when idle and start high; 33 more edges until idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (rem != 0) n_abort++;
            rem = 0;
        end else if (rem == 0) begin
            if (start) begin
                exp_q.push_back(64'(a) * 64'(b));
                n_acc++;
                rem = 33;
            end
        end else begin
            rem = rem - 1;
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            last_prod = '0;
        end else begin
            check("busy", {63'd0, busy}, {63'd0, rem != 0});
            check("done", {63'd0, done}, {63'd0, rem == 1});
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_without_request", 64'd1, 64'd0);
                end else begin
                    last_prod = exp_q.pop_front();
                    check("product", product, last_prod);
                end
            end else begin
                check("product_held", product, last_prod);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (rem != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (rem != 0) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit hold);
        wait_idle();
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        if (hold) begin
            for (int i = 0; i < 36; i++) begin
                a = $urandom;
                b = $urandom;
                @(negedge clk);
            end
        end
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        #5 rst_n = 1'b0;
        #1;
        check("reset_product", product, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(32'd7, 32'd6, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h0, 32'h1234_5678, 1'b0);
        do_op(32'h8000_0000, 32'd2, 1'b0);
        do_op(32'h0001_2345, 32'h0006_789A, 1'b1);
        do_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
        do_op(32'd9, 32'd11, 1'b0);

        // Abort an operation partway through its iterations.
        do_op(32'd3, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_product", product, 64'd0);
        check("midrun_reset_busy", {63'd0, busy}, 64'd0);
        check("midrun_reset_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd3, 32'd5, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if ((k % 50) == 0) x = 32'hFFFF_FFFF;
            if ((k % 70) == 0) y = 32'h0;
            do_op(x, y, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_acc - n_abort));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
